// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Two-client front end for the shared ALU. One request is granted at a time
// (round-robin on ties), driven onto the ALU for the operation's latency, and
// the captured result is returned to the granted client.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make client 0 win every tie.
//
// state | meaning
// IDLE  | no operation; grant computed combinationally, request accepted here
// ISSUE | first ALU cycle; latency counter loaded
// WAIT  | ALU inputs held while the counter runs down to its terminal count
// RESP  | result held for the granted client until it is taken
module alu_req_arbiter #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DWIDTH-1:0] req0_opa,
    input  logic [DWIDTH-1:0] req0_opb,
    input  logic [CWIDTH-1:0] req0_cmd,
    input  logic              req0_mode,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DWIDTH-1:0] req1_opa,
    input  logic [DWIDTH-1:0] req1_opb,
    input  logic [CWIDTH-1:0] req1_cmd,
    input  logic              req1_mode,
    input  logic              req1_cin,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DWIDTH:0]   rsp0_res,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH:0]   rsp1_res,
    output logic              alu_ce,
    output logic [DWIDTH-1:0] alu_opa,
    output logic [DWIDTH-1:0] alu_opb,
    output logic [CWIDTH-1:0] alu_cmd,
    output logic              alu_mode,
    output logic              alu_cin,
    output logic [1:0]        alu_inp_valid,
    input  logic [DWIDTH:0]   alu_res,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CWIDTH-1:0] CMD_ADD_MUL = CWIDTH'(9);
    localparam logic [CWIDTH-1:0] CMD_SH_MUL  = CWIDTH'(10);

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              accept;
    logic              last_q;
    logic              gnt_q;
    logic              rsp_ready_g;
    logic              wait_tc;
    logic [DWIDTH-1:0] sel_opa;
    logic [DWIDTH-1:0] sel_opb;
    logic [CWIDTH-1:0] sel_cmd;
    logic              sel_mode;
    logic              sel_cin;
    logic [1:0]        lat_nxt;
    logic [DWIDTH-1:0] opa_q;
    logic [DWIDTH-1:0] opb_q;
    logic [CWIDTH-1:0] cmd_q;
    logic              mode_q;
    logic              cin_q;
    logic [1:0]        lat_q;
    logic [1:0]        cnt_q;
    logic [DWIDTH:0]   res_q;

    // Pick the winner: on a tie the client not served last wins (or client 0 in the fixed build)
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = ~req0_valid;
        end
`endif
    end

    // Winner's request fields and the latency its operation needs
    always_comb begin
        sel_opa  = grant ? req1_opa  : req0_opa;
        sel_opb  = grant ? req1_opb  : req0_opb;
        sel_cmd  = grant ? req1_cmd  : req0_cmd;
        sel_mode = grant ? req1_mode : req0_mode;
        sel_cin  = grant ? req1_cin  : req0_cin;
        lat_nxt  = 2'd1;
        if (sel_mode && (sel_cmd == CMD_ADD_MUL || sel_cmd == CMD_SH_MUL)) begin
            lat_nxt = 2'd3;
        end
    end

    // Counter value 1 means it reaches zero on this edge: last WAIT cycle
    assign wait_tc     = (cnt_q == 2'd1);
    assign rsp_ready_g = gnt_q ? rsp1_ready : rsp0_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and request handshake
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    accept     = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (wait_tc) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_g) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operation latch, latency down-counter, result capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q  <= '0;
            opb_q  <= '0;
            cmd_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
            gnt_q  <= 1'b0;
            lat_q  <= 2'd0;
            cnt_q  <= 2'd0;
            res_q  <= '0;
            last_q <= 1'b1;
        end else begin
            if (accept) begin
                opa_q  <= sel_opa;
                opb_q  <= sel_opb;
                cmd_q  <= sel_cmd;
                mode_q <= sel_mode;
                cin_q  <= sel_cin;
                gnt_q  <= grant;
                lat_q  <= lat_nxt;
            end
            if (state == ISSUE) begin
                cnt_q <= lat_q;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (state == WAIT && wait_tc) begin
                res_q <= alu_res;
            end
            if (state == RESP && rsp_ready_g) begin
                last_q <= gnt_q;
            end
        end
    end

    // Operands stay on the ALU outside ISSUE/WAIT so its output remains frozen
    assign alu_ce        = (state == ISSUE) || (state == WAIT);
    assign alu_inp_valid = {2{alu_ce}};
    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;

    assign rsp0_valid = (state == RESP) && !gnt_q;
    assign rsp1_valid = (state == RESP) && gnt_q;
    assign rsp0_res   = rsp0_valid ? res_q : '0;
    assign rsp1_res   = rsp1_valid ? res_q : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: randomized requests from both clients against
// a transaction-level reference model; expected responses go into a queue that
// a separate monitor drains whenever the DUT presents a response.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       req_valid [2];
    logic [7:0] req_opa [2];
    logic [7:0] req_opb [2];
    logic [3:0] req_cmd [2];
    logic       req_mode [2];
    logic       req_cin [2];
    logic       rsp_ready [2];

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [8:0] rsp0_res, rsp1_res;
    logic       alu_ce, alu_mode, alu_cin, busy;
    logic [7:0] alu_opa, alu_opb;
    logic [3:0] alu_cmd;
    logic [1:0] alu_inp_valid;
    logic [8:0] alu_res = 9'h0;

    logic       rsp_valid_w [2];
    logic [8:0] rsp_res_w [2];
    assign rsp_valid_w[0] = rsp0_valid;
    assign rsp_valid_w[1] = rsp1_valid;
    assign rsp_res_w[0]   = rsp0_res;
    assign rsp_res_w[1]   = rsp1_res;

    alu_req_arbiter #(.DWIDTH(8), .CWIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req0_ready),
        .req0_opa(req_opa[0]), .req0_opb(req_opb[0]), .req0_cmd(req_cmd[0]),
        .req0_mode(req_mode[0]), .req0_cin(req_cin[0]),
        .req1_valid(req_valid[1]), .req1_ready(req1_ready),
        .req1_opa(req_opa[1]), .req1_opb(req_opb[1]), .req1_cmd(req_cmd[1]),
        .req1_mode(req_mode[1]), .req1_cin(req_cin[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_ready[0]), .rsp0_res(rsp0_res),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_ready[1]), .rsp1_res(rsp1_res),
        .alu_ce(alu_ce), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
        .alu_res(alu_res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU function (mode 1 arithmetic, mode 0 logical)
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] cmd, input logic mode, input logic cin);
        int x;
        if (mode) begin
            case (cmd)
                4'd0:    x = int'(a) + int'(b);
                4'd1:    x = int'(a) - int'(b);
                4'd2:    x = int'(a) + int'(b) + int'(cin);
                4'd9:    x = (int'(a) + 1) * (int'(b) + 1);
                4'd10:   x = (int'(a) * 2) * int'(b);
                default: x = int'({cin, a ^ ~b});
            endcase
        end else begin
            case (cmd)
                4'd0:    x = int'(a & b);
                4'd1:    x = int'(a | b);
                4'd2:    x = int'(a ^ b);
                default: x = int'({cin, ~(a ^ b) ^ {4'b0, cmd}});
            endcase
        end
        return x[8:0];
    endfunction

    function automatic int ref_lat(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 1;
    endfunction

    // ALU stand-in: result only becomes correct after the operation's latency in ce cycles
    int alu_n = 0;
    always @(posedge clk) begin
        if (alu_ce) begin
            alu_n <= alu_n + 1;
            if (alu_n + 1 >= ref_lat(alu_mode, alu_cmd))
                alu_res <= ref_alu(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);
            else
                alu_res <= 9'h155;
        end else begin
            alu_n <= 0;
        end
    end

    typedef struct {
        int         client;
        logic [8:0] res;
        int         due;
    } exp_t;
    exp_t sb [$];

    // Reference model state: one operation in flight at most
    bit         out_valid = 1'b0;
    int         out_client = 0;
    int         out_due = 0;
    logic [7:0] out_opa, out_opb;
    logic [3:0] out_cmd;
    logic       out_mode, out_cin;
    int         last_m = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int c, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] cmd, input logic mode, input logic cin);
        req_valid[c] = 1'b1;
        req_opa[c]   = a;
        req_opb[c]   = b;
        req_cmd[c]   = cmd;
        req_mode[c]  = mode;
        req_cin[c]   = cin;
    endtask

    task automatic rand_req(input int c);
        int r;
        logic [3:0] cmd;
        r = int'($urandom_range(3));
        cmd = (r == 0) ? 4'd9 : (r == 1) ? 4'd10 : 4'($urandom_range(15));
        set_req(c, 8'($urandom), 8'($urandom), cmd, 1'($urandom), 1'($urandom));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_ce,
                                 alu_mode, alu_cin, alu_inp_valid, busy}), 32'd0);
        chk({name, "_res"}, 32'({rsp0_res, rsp1_res}), 32'd0);
        chk({name, "_ops"}, 32'({alu_opa, alu_opb, alu_cmd}), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        out_valid = 1'b0;
        last_m = 1;
        sb.delete();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
    endtask

    // One cycle per iteration: predict and check at negedge, drive new inputs after posedge
    task automatic run_cycles(input int n, input int pv0, input int pv1, input int pr0, input int pr1);
        for (int k = 0; k < n; k++) begin
            bit   acc [2];
            int   w;
            bit   exp_ce;
            exp_t e;
            acc[0] = 1'b0;
            acc[1] = 1'b0;
            @(negedge clk);
            w = -1;
            if (!out_valid && (req_valid[0] || req_valid[1])) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                w = req_valid[0] ? 0 : 1;
`else
                if (req_valid[0] && req_valid[1]) w = 1 - last_m;
                else w = req_valid[0] ? 0 : 1;
`endif
            end
            chk("req0_ready", 32'(req0_ready), 32'(w == 0));
            chk("req1_ready", 32'(req1_ready), 32'(w == 1));
            chk("busy", 32'(busy), 32'(out_valid));
            exp_ce = out_valid && (cyc < out_due);
            chk("alu_ce", 32'(alu_ce), 32'(exp_ce));
            chk("alu_inp_valid", 32'(alu_inp_valid), exp_ce ? 32'd3 : 32'd0);
            if (exp_ce)
                chk("alu_fields", 32'({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}),
                    32'({out_opa, out_opb, out_cmd, out_mode, out_cin}));
            if (w >= 0) begin
                out_valid  = 1'b1;
                out_client = w;
                out_opa    = req_opa[w];
                out_opb    = req_opb[w];
                out_cmd    = req_cmd[w];
                out_mode   = req_mode[w];
                out_cin    = req_cin[w];
                out_due    = cyc + 2 + ref_lat(out_mode, out_cmd);
                e.client   = w;
                e.res      = ref_alu(out_opa, out_opb, out_cmd, out_mode, out_cin);
                e.due      = out_due;
                sb.push_back(e);
                acc[w]     = 1'b1;
            end else if (out_valid && cyc >= out_due && rsp_ready[out_client]) begin
                out_valid = 1'b0;
                last_m    = out_client;
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (acc[c]) req_valid[c] = 1'b0;
                if (!req_valid[c] && int'($urandom_range(99)) < (c == 1 ? pv1 : pv0)) rand_req(c);
                rsp_ready[c] = int'($urandom_range(99)) < (c == 1 ? pr1 : pr0);
            end
        end
    endtask

    // Response monitor: pops the scoreboard on each completed response handshake
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (rsp_valid_w[c]) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: client %0d valid with res %0h, expected no response (cycle %0d)",
                                 c, rsp_res_w[c], cyc);
                    end else begin
                        chk("rsp_client", 32'(c), 32'(sb[0].client));
                        chk("rsp_res", 32'(rsp_res_w[c]), 32'(sb[0].res));
                        if (!seen) begin
                            chk("rsp_latency", 32'(cyc), 32'(sb[0].due));
                            seen = 1'b1;
                        end
                        if (rsp_ready[c]) begin
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end else begin
                    chk("rsp_res_idle", 32'(rsp_res_w[c]), 32'd0);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            req_valid[c] = 1'b0;
            req_opa[c]   = 8'h0;
            req_opb[c]   = 8'h0;
            req_cmd[c]   = 4'h0;
            req_mode[c]  = 1'b0;
            req_cin[c]   = 1'b0;
            rsp_ready[c] = 1'b0;
        end
        do_reset(2);

        // ADD 0xFF + 0x01 -> 0x100
        set_req(0, 8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
        run_cycles(6, 0, 0, 100, 100);
        // ADD_MUL on client 1: (3+1)*(4+1) = 20
        set_req(1, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0);
        run_cycles(8, 0, 0, 100, 100);
        // Logical AND 0xF0 & 0x3C -> 0x030
        set_req(0, 8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0);
        run_cycles(6, 0, 0, 100, 100);

        // Both clients always requesting, responses taken at once
        run_cycles(40, 100, 100, 100, 100);
        run_cycles(12, 0, 0, 100, 100);

        // Response backpressure on client 0 while client 1 waits
        set_req(0, 8'h12, 8'h34, 4'd1, 1'b1, 1'b0);
        set_req(1, 8'h56, 8'h78, 4'd2, 1'b1, 1'b1);
        run_cycles(14, 0, 0, 0, 100);
        run_cycles(12, 0, 0, 100, 100);

        // Reset in the middle of a multiply: the operation must vanish
        set_req(0, 8'd5, 8'd6, 4'd9, 1'b1, 1'b1);
        run_cycles(3, 0, 0, 100, 100);
        do_reset(2);
        run_cycles(10, 0, 0, 100, 100);

        // Random traffic with varying response backpressure
        run_cycles(400, 40, 40, 70, 70);
        run_cycles(200, 80, 80, 30, 90);
        run_cycles(40, 0, 0, 100, 100);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
